// File: rtl/block_ecc_encode.sv
// Block ECC encoder: buffers a 17x16 data block, builds the row, column and
// two diagonal parity planes, then streams the 19x18 encoded block row by row
// in the layout the read-side decoder/corrector expects.
module block_ecc_encode (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_data,
  output logic [4:0]  out_row,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [1:0] {StFill, StCalc, StDrain} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [4:0]  row_q;
  logic [15:0] buf_q [17];
  logic [15:0] col_q;
  logic [15:0] anti_q;
  logic [16:0] diag_q, diag_c;
  logic [18:0] rpar_q, rpar_c;
  logic        in_hs, out_hs;
  logic [31:0] in_dbl;
  logic [15:0] in_rot;
  logic [4:0]  data_idx;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  assign busy   = !((state_q == StFill) && (cnt_q == 5'd0));

  // Word k feeds the anti-diagonal plane rotated right by (k mod 16).
  assign in_dbl = {in_data, in_data};
  assign in_rot = in_dbl[cnt_q[3:0] +: 16];

  // Diagonal column and row parity, evaluated from the full buffer in CALC.
  always_comb begin
    diag_c = '0;
    for (int m = 0; m < 17; m++) begin
      for (int k = 0; k < 16; k++) begin
        diag_c[m] = diag_c[m] ^ buf_q[(m + k) % 17][k];
      end
    end
    rpar_c    = '0;
    rpar_c[0] = ^col_q;
    rpar_c[1] = ^anti_q;
    for (int r = 2; r < 19; r++) begin
      rpar_c[r] = (^buf_q[r - 2]) ^ diag_c[r - 2];
    end
  end

  // Next-state logic and stream outputs; outputs idle at zero outside DRAIN.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_row   = '0;
    out_last  = 1'b0;
    data_idx  = row_q - 5'd2;
    unique case (state_q)
      StFill: begin
        in_ready = 1'b1;
        if (in_valid && (cnt_q == 5'd16)) state_d = StCalc;
      end
      StCalc: begin
        state_d = StDrain;
      end
      StDrain: begin
        out_valid = 1'b1;
        out_row   = row_q;
        out_last  = (row_q == 5'd18);
        if (row_q == 5'd0) begin
          out_data = {col_q, 1'b0, rpar_q[0]};
        end else if (row_q == 5'd1) begin
          out_data = {anti_q, 1'b0, rpar_q[1]};
        end else begin
          out_data = {buf_q[data_idx], diag_q[data_idx], rpar_q[row_q]};
        end
        if (out_ready && out_last) state_d = StFill;
      end
      default: state_d = StFill;
    endcase
  end

  // State, buffer and parity accumulators; reset discards any partial block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFill;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      anti_q  <= '0;
      diag_q  <= '0;
      rpar_q  <= '0;
      for (int i = 0; i < 17; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (in_hs) begin
        buf_q[cnt_q] <= in_data;
        col_q        <= col_q ^ in_data;
        anti_q       <= anti_q ^ in_rot;
        cnt_q        <= cnt_q + 5'd1;
      end
      if (state_q == StCalc) begin
        diag_q <= diag_c;
        rpar_q <= rpar_c;
        row_q  <= '0;
      end
      if (out_hs) begin
        if (out_last) begin
          cnt_q  <= '0;
          col_q  <= '0;
          anti_q <= '0;
          row_q  <= '0;
        end else begin
          row_q <= row_q + 5'd1;
        end
      end
    end
  end

endmodule
